// File: rtl/axi_sram_slave_pkg.sv
// Shared response codes and FSM encodings for the AXI3 single-beat SRAM slave.
package axi_sram_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE,
    R_MEM,
    R_WAIT,
    R_RESP
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_MEM,
    W_RESP
  } w_state_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        err;
  } wr_req_t;

endpackage

// File: rtl/sp_ram_bw.sv
// Synchronous single-port 32-bit RAM with byte enables and 1-cycle read.
module sp_ram_bw #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<AW)-1];

  // rdata only moves on a read, so it holds while a response waits
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 single-beat SRAM slave, independent read/write FSMs on one RAM port.
// Define AXI_SLV_OOR_ERR_EN to answer out-of-range addresses with SLVERR.
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int MEM_AW  = 10,
  parameter int RD_WAIT = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam logic [3:0] WAIT_INIT =
    (RD_WAIT == 0) ? 4'd0 : 4'(RD_WAIT - 1);

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;

  logic [3:0]        rid_r;
  logic [MEM_AW-1:0] raddr_r;
  logic              r_err;
  logic [3:0]        cnt;
  logic              rd_issue;

  logic [MEM_AW-1:0] waddr_r;
  logic              aw_err;
  wr_req_t           wr;
  logic              aw_got;
  logic              w_got;

  logic              ar_oor;
  logic              aw_oor;
  logic              ar_hs;
  logic              aw_hs;
  logic              w_hs;

  logic              ram_en;
  logic              ram_we;
  logic [MEM_AW-1:0] ram_addr;
  logic [31:0]       ram_q;

`ifdef AXI_SLV_OOR_ERR_EN
  assign ar_oor = |araddr[31:MEM_AW+2];
  assign aw_oor = |awaddr[31:MEM_AW+2];
`else
  assign ar_oor = 1'b0;
  assign aw_oor = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{arlen, arsize, arburst, arlock,
                       arcache, arprot, araddr,
                       awlen, awsize, awburst, awlock,
                       awcache, awprot, awaddr,
                       wid, wlast};

  assign ar_hs = arvalid && arready;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  always_comb begin
    r_next   = r_state;
    arready  = 1'b0;
    rd_issue = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) r_next = R_MEM;
      end
      // a write owning the port pushes the read back a cycle
      R_MEM: begin
        if (w_state != W_MEM) begin
          rd_issue = 1'b1;
          r_next   = (RD_WAIT == 0) ? R_RESP : R_WAIT;
        end
      end
      R_WAIT: begin
        if (cnt == 4'd0) r_next = R_RESP;
      end
      R_RESP: begin
        if (rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= R_IDLE;
      rid_r   <= '0;
      raddr_r <= '0;
      r_err   <= 1'b0;
      cnt     <= '0;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        rid_r   <= arid;
        raddr_r <= araddr[MEM_AW+1:2];
        r_err   <= ar_oor;
      end
      if (rd_issue) cnt <= WAIT_INIT;
      else if (r_state == R_WAIT && cnt != 4'd0)
        cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        awready = !aw_got;
        wready  = !w_got;
        if ((aw_got || awvalid) && (w_got || wvalid))
          w_next = W_MEM;
      end
      W_MEM:  w_next = W_RESP;
      W_RESP: begin
        if (bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_state <= W_IDLE;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      waddr_r <= '0;
      aw_err  <= 1'b0;
      wr      <= '0;
    end else begin
      w_state <= w_next;
      if (aw_hs) begin
        wr.id   <= awid;
        wr.err  <= aw_oor;
        waddr_r <= awaddr[MEM_AW+1:2];
        aw_err  <= aw_oor;
      end
      if (w_hs) begin
        wr.data <= wdata;
        wr.strb <= wstrb;
      end
      if (w_state == W_IDLE && w_next == W_MEM) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        aw_got <= aw_got || aw_hs;
        w_got  <= w_got || w_hs;
      end
    end
  end

  assign ram_we   = (w_state == W_MEM) && !aw_err;
  assign ram_en   = ram_we || rd_issue;
  assign ram_addr = (w_state == W_MEM) ? waddr_r : raddr_r;

  sp_ram_bw #(.AW(MEM_AW)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (wr.strb),
    .addr  (ram_addr),
    .wdata (wr.data),
    .rdata (ram_q)
  );

  assign rvalid = (r_state == R_RESP);
  assign rid    = rid_r;
  assign rlast  = 1'b1;
  assign rresp  = (rvalid && r_err) ? RESP_SLVERR : RESP_OKAY;
  assign rdata  = (rvalid && !r_err) ? ram_q : 32'd0;

  assign bvalid = (w_state == W_RESP);
  assign bid    = wr.id;
  assign bresp  = (bvalid && wr.err) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed scoreboard bench for axi_sram_slave (MEM_AW=10, RD_WAIT=2).
module tb_axi_sram_slave;

  localparam int RDW = 2;
`ifdef AXI_SLV_OOR_ERR_EN
  localparam bit OOR_EN = 1'b1;
`else
  localparam bit OOR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  logic [3:0] arid, rid, awid, wid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, arprot, awsize, awprot;
  logic [1:0] arburst, arlock, awburst, awlock, rresp, bresp;
  logic [3:0] arcache, awcache, wstrb;
  logic arvalid, arready, rlast, rvalid, rready;
  logic awvalid, awready, wlast, wvalid, wready;
  logic bvalid, bready;

  always #5 clk = ~clk;

  axi_sram_slave #(.MEM_AW(10), .RD_WAIT(RDW)) dut (
    .clk(clk), .resetn(resetn),
    .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid),
    .bready(bready)
  );

  typedef struct {
    logic [3:0]  id;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  exp_t rq[$];
  exp_t bq[$];
  logic [31:0] mem [0:1023];
  int total = 0;
  int npass = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic bit oor(logic [31:0] a);
    return OOR_EN && (a[31:12] != 20'd0);
  endfunction

  task automatic push_w(logic [31:0] a, logic [31:0] d,
                        logic [3:0] s, logic [3:0] id);
    exp_t e;
    if (!oor(a))
      for (int i = 0; i < 4; i++)
        if (s[i]) mem[a[11:2]][8*i +: 8] = d[8*i +: 8];
    e.id = id;
    e.resp = oor(a) ? 2'b10 : 2'b00;
    e.data = '0;
    bq.push_back(e);
  endtask

  task automatic push_r(logic [31:0] a, logic [3:0] id);
    exp_t e;
    e.id = id;
    e.resp = oor(a) ? 2'b10 : 2'b00;
    e.data = oor(a) ? 32'd0 : mem[a[11:2]];
    rq.push_back(e);
  endtask

  task automatic check_reset_outputs(string pfx);
    chk({pfx, "_arready"}, arready, 1);
    chk({pfx, "_awready"}, awready, 1);
    chk({pfx, "_wready"}, wready, 1);
    chk({pfx, "_rvalid"}, rvalid, 0);
    chk({pfx, "_bvalid"}, bvalid, 0);
    chk({pfx, "_rresp"}, rresp, 0);
    chk({pfx, "_bresp"}, bresp, 0);
    chk({pfx, "_rlast"}, rlast, 1);
    chk({pfx, "_rid"}, rid, 0);
    chk({pfx, "_bid"}, bid, 0);
    chk({pfx, "_rdata"}, rdata, 0);
  endtask

  task automatic finish_b();
    exp_t e;
    chk("bvalid", bvalid, 1);
    e = bq.pop_front();
    chk("bid", bid, e.id);
    chk("bresp", bresp, e.resp);
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("b_done", bvalid, 0);
  endtask

  task automatic finish_r(int hold);
    exp_t e;
    chk("rvalid", rvalid, 1);
    e = rq.pop_front();
    chk("rdata", rdata, e.data);
    chk("rid", rid, e.id);
    chk("rresp", rresp, e.resp);
    chk("rlast", rlast, 1);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_rvalid", rvalid, 1);
      chk("hold_rdata", rdata, e.data);
      chk("hold_rid", rid, e.id);
      chk("hold_arready", arready, 0);
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
    chk("r_done", rvalid, 0);
    chk("r_arready", arready, 1);
  endtask

  task automatic wait_b(int lat);
    int n = 1;
    while (!bvalid && n < 20) begin
      step();
      n++;
    end
    chk("b_lat", n, lat);
    finish_b();
  endtask

  task automatic wait_r(int lat, int hold);
    int n = 1;
    while (!rvalid && n < 30) begin
      step();
      n++;
    end
    chk("r_lat", n, lat);
    finish_r(hold);
  endtask

  task automatic write(logic [31:0] a, logic [31:0] d,
                       logic [3:0] s, logic [3:0] id);
    push_w(a, d, s, id);
    awaddr = a; awid = id; awvalid = 1'b1;
    wdata = d; wstrb = s; wid = id; wvalid = 1'b1;
    step();
    awvalid = 1'b0;
    wvalid = 1'b0;
    wait_b(2);
  endtask

  task automatic read(logic [31:0] a, logic [3:0] id, int hold);
    push_r(a, id);
    araddr = a; arid = id; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    wait_r(2 + RDW, hold);
  endtask

  initial begin
    #100000;
    $error("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bl, rl, n;
    foreach (mem[i]) mem[i] = '0;
    resetn = 1'b0;
    arid = 0; araddr = 0; arvalid = 0; rready = 0;
    awid = 0; awaddr = 0; awvalid = 0;
    wid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    arlen = 0; arsize = 3'd2; arburst = 2'd1; arlock = 0;
    arcache = 0; arprot = 0; awlen = 0; awsize = 3'd2;
    awburst = 2'd1; awlock = 0; awcache = 0; awprot = 0;
    wlast = 1'b1;
    step();
    step();
    check_reset_outputs("rst");
    resetn = 1'b1;
    step();

    write(32'h10, 32'hDEADBEEF, 4'hF, 4'd3);
    read(32'h10, 4'd5, 0);

    // W beat three cycles ahead of its AW
    push_w(32'h10, 32'h0000AB00, 4'b0010, 4'd6);
    wdata = 32'h0000AB00; wstrb = 4'b0010;
    wid = 4'd9; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    chk("wfirst_wready", wready, 0);
    chk("wfirst_awready", awready, 1);
    chk("wfirst_bvalid", bvalid, 0);
    step();
    step();
    awaddr = 32'h10; awid = 4'd6; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    wait_b(2);
    read(32'h10, 4'd1, 0);

    read(32'h10, 4'd2, 5);

    write(32'h10, 32'h12345678, 4'h0, 4'd1);
    read(32'h10, 4'd4, 0);
    write(32'hFFC, 32'hA5A5C3C3, 4'hF, 4'd15);
    read(32'hFFC, 4'd15, 0);

    // AR and AW+W together on one word
    push_w(32'h20, 32'hCAFEF00D, 4'hF, 4'd4);
    push_r(32'h20, 4'd7);
    awaddr = 32'h20; awid = 4'd4; awvalid = 1'b1;
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wid = 4'd4;
    wvalid = 1'b1;
    araddr = 32'h20; arid = 4'd7; arvalid = 1'b1;
    step();
    awvalid = 0; wvalid = 0; arvalid = 0;
    n = 1; bl = 0; rl = 0;
    while ((bl == 0 || rl == 0) && n < 30) begin
      if (bvalid && bl == 0) bl = n;
      if (rvalid && rl == 0) rl = n;
      if (bl == 0 || rl == 0) begin
        step();
        n++;
      end
    end
    chk("col_b_lat", bl, 2);
    chk("col_r_lat", rl, 3 + RDW);
    finish_b();
    finish_r(0);

    // reset with a write response and a read both outstanding
    mem[16] = 32'h55AA55AA;
    awaddr = 32'h40; awid = 4'd11; awvalid = 1'b1;
    wdata = 32'h55AA55AA; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 32'h44; arid = 4'd12; arvalid = 1'b1;
    step();
    awvalid = 0; wvalid = 0; arvalid = 0;
    step();
    chk("mid_bvalid", bvalid, 1);
    chk("mid_rvalid", rvalid, 0);
    resetn = 1'b0;
    step();
    check_reset_outputs("mid");
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("post_bvalid", bvalid, 0);
      chk("post_rvalid", rvalid, 0);
    end
    read(32'h40, 4'd13, 0);

    write(32'h0, 32'h11223344, 4'hF, 4'd2);
    write(32'h1000, 32'h99887766, 4'hF, 4'd8);
    read(32'h1000, 4'd3, 0);
    read(32'h0, 4'd10, 0);

    $display("%0d/%0d checks passed", npass, total);
    $finish;
  end

endmodule
